// File: rtl/updown_counter8_core_if.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter8_core_if
// Description : Control/status bundle between a driver and updown_counter8_core.
// Revision    : 1.0 - initial release
// ============================================================================
interface updown_counter8_core_if #(
    parameter int WIDTH = 8
);
    logic             tick_in;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             dir_o;

    modport master (
        output tick_in, en, up_dn, load, load_val,
        input  count, tc, dir_o
    );

    modport slave (
        input  tick_in, en, up_dn, load, load_val,
        output count, tc, dir_o
    );
endinterface
`default_nettype wire

// File: rtl/updown_counter8_core.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter8_core
// Description : Up/down counter stepped by synchronized rising edges of tick_in,
//               with clamped load, wrap (or bounce with COUNT_BOUNCE_EN) and tc.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter8_core #(
    parameter int WIDTH       = 8,
    parameter int MAX_VAL     = 255,
    parameter int MIN_VAL     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    updown_counter8_core_if.slave      bus
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_min = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
`ifdef COUNT_BOUNCE_EN
    localparam logic [WIDTH-1:0] c_up_limit_next = WIDTH'(MAX_VAL - 1);
    localparam logic [WIDTH-1:0] c_dn_limit_next = WIDTH'(MIN_VAL + 1);
`else
    localparam logic [WIDTH-1:0] c_up_limit_next = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_dn_limit_next = WIDTH'(MAX_VAL);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [WIDTH-1:0]       r_count;
    logic                   r_tc;
    logic                   r_dir;
    logic                   w_step;
    logic                   w_at_limit;
    logic [WIDTH-1:0]       w_load_lo;
    logic [WIDTH-1:0]       w_load_clamped;

    assign w_step     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
    assign w_at_limit = ((r_state == S_UP)   && (r_count == c_max)) ||
                        ((r_state == S_DOWN) && (r_count == c_min));

    // Clamp comparisons only exist when a limit is narrower than the full range.
    generate
        if (MIN_VAL > 0) begin : g_min_clamp
            assign w_load_lo = (bus.load_val < c_min) ? c_min : bus.load_val;
        end else begin : g_min_pass
            assign w_load_lo = bus.load_val;
        end
        if (MAX_VAL < (2 ** WIDTH) - 1) begin : g_max_clamp
            assign w_load_clamped = (w_load_lo > c_max) ? c_max : w_load_lo;
        end else begin : g_max_pass
            assign w_load_clamped = w_load_lo;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
`ifdef COUNT_BOUNCE_EN
        // Direction is latched on leaving idle; afterwards only the limits reverse it.
        case (r_state)
            S_IDLE: begin
                if (bus.en) w_state_nxt = bus.up_dn ? S_UP : S_DOWN;
            end
            default: begin
                if (!bus.en)
                    w_state_nxt = S_IDLE;
                else if (w_step && !bus.load && w_at_limit)
                    w_state_nxt = (r_state == S_UP) ? S_DOWN : S_UP;
            end
        endcase
`else
        if (!bus.en)
            w_state_nxt = S_IDLE;
        else
            w_state_nxt = bus.up_dn ? S_UP : S_DOWN;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_count  <= c_min;
            r_tc     <= 1'b0;
            r_dir    <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.tick_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
            r_state  <= w_state_nxt;
            r_tc     <= 1'b0;
            if (w_state_nxt == S_UP)
                r_dir <= 1'b1;
            else if (w_state_nxt == S_DOWN)
                r_dir <= 1'b0;

            // Steps act on the current state; a direction change applies to the next one.
            if (bus.load) begin
                r_count <= w_load_clamped;
            end else if (w_step && (r_state == S_UP)) begin
                if (r_count == c_max) begin
                    r_count <= c_up_limit_next;
                    r_tc    <= 1'b1;
                end else begin
                    r_count <= r_count + c_one;
                end
            end else if (w_step && (r_state == S_DOWN)) begin
                if (r_count == c_min) begin
                    r_count <= c_dn_limit_next;
                    r_tc    <= 1'b1;
                end else begin
                    r_count <= r_count - c_one;
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.dir_o = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter8_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter8_core
// Description : Directed vector bench for updown_counter8_core (both build modes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter8_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    updown_counter8_core_if #(.WIDTH(8)) bus1 ();
    updown_counter8_core_if #(.WIDTH(8)) bus2 ();

    assign bus2.tick_in  = bus1.tick_in;
    assign bus2.en       = bus1.en;
    assign bus2.up_dn    = bus1.up_dn;
    assign bus2.load     = bus1.load;
    assign bus2.load_val = bus1.load_val;

    updown_counter8_core #(.WIDTH(8), .MAX_VAL(255), .MIN_VAL(0), .SYNC_STAGES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Narrowed limits for the load clamp checks.
    updown_counter8_core #(.WIDTH(8), .MAX_VAL(200), .MIN_VAL(16), .SYNC_STAGES(2)) u_dut_lim (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        bit         ld;
        logic [7:0] lv;
        bit         en;
        bit         ud;
        bit         tick;
        logic [7:0] exp_cnt;
        bit         exp_tc;
        bit         exp_dir;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_cnt = 8'h00;
    vec_t       tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Rising tick_in just after edge n; the count must move at edge n+3.
    task automatic do_tick(input logic [7:0] exp_cnt, input bit exp_tc, input bit exp_dir);
        bus1.tick_in = 1'b1;
        cyc();
        cyc();
        chk("latency_hold", bus1.count, m_cnt);
        cyc();
        chk("tick_count", bus1.count, exp_cnt);
        chk("tick_tc", bus1.tc, exp_tc);
        chk("tick_dir", bus1.dir_o, exp_dir);
        m_cnt = exp_cnt;
        bus1.tick_in = 1'b0;
        cyc();
        chk("tc_one_cycle", bus1.tc, 1'b0);
        cyc();
        cyc();
        cyc();
    endtask

    task automatic do_load(input logic [7:0] v);
        bus1.load     = 1'b1;
        bus1.load_val = v;
        cyc();
        bus1.load     = 1'b0;
    endtask

    task automatic set_dir(input bit ud);
        bus1.en = 1'b0;
        cyc();
        bus1.en    = 1'b1;
        bus1.up_dn = ud;
        cyc();
    endtask

    function automatic vec_t mk(bit ld, logic [7:0] lv, bit en, bit ud, bit tick,
                                logic [7:0] c, bit tc, bit dir);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = en; v.ud = ud; v.tick = tick;
        v.exp_cnt = c; v.exp_tc = tc; v.exp_dir = dir;
        return v;
    endfunction

    initial begin
`ifdef COUNT_BOUNCE_EN
        tbl.push_back(mk(1, 8'hFE, 1, 1, 0, 8'hFE, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'hFE, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hFD, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'hFC, 0, 0));
        tbl.push_back(mk(1, 8'h01, 1, 1, 0, 8'h01, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h01, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h02, 0, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h02, 0, 1));
`else
        tbl.push_back(mk(1, 8'hFD, 1, 1, 0, 8'hFD, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'hFE, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 8'h01, 0, 1));
        tbl.push_back(mk(1, 8'h01, 1, 0, 0, 8'h01, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hFE, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'hFE, 0, 0));
`endif

        bus1.tick_in  = 1'b0;
        bus1.en       = 1'b0;
        bus1.up_dn    = 1'b0;
        bus1.load     = 1'b0;
        bus1.load_val = 8'h00;
        cyc();
        cyc();
        chk("reset_count", bus1.count, 8'h00);
        chk("reset_tc", bus1.tc, 1'b0);
        chk("reset_dir", bus1.dir_o, 1'b1);
        chk("reset_count_lim", bus2.count, 8'h10);
        rst = 1'b0;
        cyc();

        foreach (tbl[i]) begin
            bus1.en    = tbl[i].en;
            bus1.up_dn = tbl[i].ud;
            if (tbl[i].ld) begin
                do_load(tbl[i].lv);
                chk("load_count", bus1.count, tbl[i].exp_cnt);
                chk("load_tc", bus1.tc, tbl[i].exp_tc);
                chk("load_dir", bus1.dir_o, tbl[i].exp_dir);
                m_cnt = tbl[i].exp_cnt;
            end
            if (tbl[i].tick)
                do_tick(tbl[i].exp_cnt, tbl[i].exp_tc, tbl[i].exp_dir);
        end

        // Load collides with a step: load wins and no step is deferred.
        set_dir(1'b1);
        do_load(8'h7F);
        chk("pre_collide", bus1.count, 8'h7F);
        bus1.tick_in = 1'b1;
        cyc();
        cyc();
        bus1.load     = 1'b1;
        bus1.load_val = 8'h80;
        cyc();
        bus1.load     = 1'b0;
        chk("collide_count", bus1.count, 8'h80);
        chk("collide_tc", bus1.tc, 1'b0);
        cyc();
        chk("collide_no_defer", bus1.count, 8'h80);

        // tick_in held high is a single step.
        bus1.tick_in = 1'b0;
        repeat (3) cyc();
        bus1.tick_in = 1'b1;
        repeat (50) cyc();
        chk("held_high", bus1.count, 8'h81);
        bus1.tick_in = 1'b0;
        repeat (3) cyc();
        chk("held_release", bus1.count, 8'h81);

        // Clamp on the narrowed instance.
        do_load(8'hF0);
        chk("clamp_max", bus2.count, 8'hC8);
        chk("noclamp_full", bus1.count, 8'hF0);
        do_load(8'h05);
        chk("clamp_min", bus2.count, 8'h10);
        do_load(8'h64);
        chk("clamp_pass", bus2.count, 8'h64);

        // Asynchronous reset with a step in flight.
        set_dir(1'b0);
        do_load(8'h37);
        chk("pre_reset", bus1.count, 8'h37);
        bus1.tick_in = 1'b1;
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("async_count", bus1.count, 8'h00);
        chk("async_tc", bus1.tc, 1'b0);
        chk("async_dir", bus1.dir_o, 1'b1);
        bus1.tick_in = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        chk("post_reset_hold", bus1.count, 8'h00);
        m_cnt = 8'h00;
`ifdef COUNT_BOUNCE_EN
        do_tick(8'h01, 1'b1, 1'b1);
`else
        do_tick(8'hFF, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/updown_counter8_core.md
Name: updown_counter8_core

Overview:
- 8-bit up/down counter stage directly downstream of the clock divider.
- Takes one selected divider output bit as `tick_in` and advances once per rising edge of that bit, all in the `clk` domain.
- Provides load, enable, wrap-around and a terminal-count pulse.
- Drives the board LEDs / display decoder with `count`.

Parameters:
- WIDTH, 8, counter width in bits
- MAX_VAL, 255, upper count limit (inclusive); must satisfy MIN_VAL < MAX_VAL <= 2^WIDTH-1
- MIN_VAL, 0, lower count limit (inclusive)
- SYNC_STAGES, 2, flops in the tick_in synchronizer (>=2)

Ports:
- clk  input  1  system clock (same clock feeding the divider)
- rst  input  1  asynchronous active-high reset
- tick_in  input  1  divided pulse/level from divider q bit; rising edge = one step
- en  input  1  count enable; 0 = hold
- up_dn  input  1  direction request: 1 = up, 0 = down
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current count
- tc  output  1  terminal-count pulse, one clk cycle
- dir_o  output  1  direction actually applied (1 = up)

Behaviour:
- Reset (async, rst=1): count=MIN_VAL, tc=0, dir_o=1, FSM=S_IDLE, synchronizer and edge flops cleared. Reset asserted mid-count aborts immediately; first step after release needs a fresh tick_in rising edge.
- Sync/edge detect: tick_in passes through SYNC_STAGES flops. step = sync_out & ~sync_out_d. A tick_in rise at clk edge n gives a count update visible after edge n+SYNC_STAGES+1. tick_in held high produces exactly one step.
- FSM states: S_IDLE, S_UP, S_DOWN, registered.
  - S_IDLE -> S_UP if en & up_dn; -> S_DOWN if en & ~up_dn.
  - S_UP/S_DOWN -> S_IDLE when en=0.
  - S_UP <-> S_DOWN follows up_dn. A direction change takes effect from the next step; a step in the same cycle uses the old state.
  - dir_o = 1 in S_UP, 0 in S_DOWN, holds last value in S_IDLE.
- Step in S_UP: count+1. If count==MAX_VAL, count<=MIN_VAL and tc=1 for that cycle.
- Step in S_DOWN: count-1. If count==MIN_VAL, count<=MAX_VAL and tc=1.
- Step in S_IDLE: ignored; edge state still updates, so no deferred step.
- Load (priority over step and en):
  - count<=load_val, clamped to [MIN_VAL,MAX_VAL].
  - A coincident step is discarded; tc=0.
  - FSM state is unaffected.
- tc is registered, high exactly one cycle per wrap, never two consecutive cycles.
- All arithmetic is WIDTH bits; no out-of-range value is ever visible on count.

Optional Feature:
- Macro: COUNT_BOUNCE_EN.
- Defined: at a limit the counter reverses instead of wrapping. Step at MAX_VAL in S_UP -> count=MAX_VAL-1, state S_DOWN, tc=1. Mirror behaviour at MIN_VAL. up_dn is sampled only on the S_IDLE exit; while counting, up_dn is ignored and dir_o shows the internal direction.
- Undefined: wrap-around behaviour as above; up_dn is honoured every cycle.

Test Plan:
- Reset check: rst pulse mid-count at count=0x37 -> count=0x00, tc=0, dir_o=1 within the same cycle (async), no step until the next tick_in rise.
- Up wrap: load 0xFD, en=1, up_dn=1, 4 tick_in rises -> count 0xFE, 0xFF, 0x00 (tc=1 one cycle), 0x01. Each update lands SYNC_STAGES+1 clk edges after its tick_in rise.
- Down wrap: load 0x01, up_dn=0, 3 ticks -> 0x00, 0xFF (tc=1), 0xFE.
- Load vs step collision: load=1 with load_val=0x80 in the same cycle as step -> count=0x80, not 0x81. Load with MAX_VAL=200 and load_val=0xF0 -> count=200.
- Enable/level: en=0, 5 ticks -> count unchanged. tick_in held high 50 cycles with en=1 -> exactly one increment.
- COUNT_BOUNCE_EN build: load 0xFE, up, 4 ticks -> 0xFF, 0xFE (tc=1, dir_o=0), 0xFD, 0xFC. Toggling up_dn mid-run -> no effect.
